// File: rtl/dbg_loader_pkg.sv
// Shared command/reply codes and FSM state encoding for the UART debug loader.
package dbg_loader_pkg;

  localparam logic [7:0] CMD_W   = 8'h57;
  localparam logic [7:0] CMD_B   = 8'h42;
  localparam logic [7:0] CMD_H   = 8'h48;
  localparam logic [7:0] CMD_R   = 8'h52;

  localparam logic [7:0] RSP_ACK = 8'h06;
  localparam logic [7:0] RSP_NAK = 8'h15;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR,
    ST_DATA,
    ST_WRITE,
    ST_RESP
  } state_t;

endpackage

// File: rtl/dbg_timeout.sv
// Inter-byte timeout counter: cleared while disabled or on reload, flags expiry at the limit.
module dbg_timeout #(
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic clk,
  input  logic n_reset,
  input  logic i_enable,
  input  logic i_reload,
  output logic o_expired
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT_CYCLES);

  logic [CW-1:0] r_count;

  // Saturates at the limit so expiry stays asserted until the FSM leaves the frame.
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      r_count <= '0;
    end else if (!i_enable || i_reload) begin
      r_count <= '0;
    end else if (r_count != LIMIT) begin
      r_count <= r_count + CW'(1);
    end
  end

  assign o_expired = i_enable && !i_reload && (r_count == LIMIT);

endmodule

// File: rtl/dbg_uart_loader.sv
// UART byte-stream decoder driving debug-port writes and the core reset, with ACK/NAK replies.
import dbg_loader_pkg::*;

module dbg_uart_loader #(
  parameter int TIMEOUT_CYCLES = 100000,
  parameter bit HOLD_ON_RESET  = 1'b1
) (
  input  logic        clk,
  input  logic        n_reset,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        cpu_n_reset,
  output logic        dbg_mem_op,
  output logic [3:0]  dbg_wren,
  output logic [31:0] dbg_adr,
  output logic [31:0] dbg_do,
  input  logic        dbg_ack
);

  state_t      r_state,     w_stateNext;
  logic [1:0]  r_cnt,       w_cntNext;
  logic        r_isWord,    w_isWordNext;
  logic [31:0] r_addr,      w_addrNext;
  logic [31:0] r_data,      w_dataNext;
  logic        r_memOp,     w_memOpNext;
  logic [3:0]  r_wren,      w_wrenNext;
  logic [31:0] r_adr,       w_adrNext;
  logic [31:0] r_do,        w_doNext;
  logic        r_txValid,   w_txValidNext;
  logic [7:0]  r_txData,    w_txDataNext;
  logic        r_cpuNReset, w_cpuNResetNext;

  logic        w_tmoEnable;
  logic        w_expired;

  assign w_tmoEnable = (r_state == ST_ADDR) || (r_state == ST_DATA);

  dbg_timeout #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_timeout (
    .clk       (clk),
    .n_reset   (n_reset),
    .i_enable  (w_tmoEnable),
    .i_reload  (rx_valid),
    .o_expired (w_expired)
  );

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      r_state     <= ST_IDLE;
      r_cnt       <= '0;
      r_isWord    <= 1'b0;
      r_addr      <= '0;
      r_data      <= '0;
      r_memOp     <= 1'b0;
      r_wren      <= '0;
      r_adr       <= '0;
      r_do        <= '0;
      r_txValid   <= 1'b0;
      r_txData    <= '0;
      r_cpuNReset <= !HOLD_ON_RESET;
    end else begin
      r_state     <= w_stateNext;
      r_cnt       <= w_cntNext;
      r_isWord    <= w_isWordNext;
      r_addr      <= w_addrNext;
      r_data      <= w_dataNext;
      r_memOp     <= w_memOpNext;
      r_wren      <= w_wrenNext;
      r_adr       <= w_adrNext;
      r_do        <= w_doNext;
      r_txValid   <= w_txValidNext;
      r_txData    <= w_txDataNext;
      r_cpuNReset <= w_cpuNResetNext;
    end
  end

  // Address and data arrive LSB first, so each byte is shifted in from the top.
  always_comb begin
    w_stateNext     = r_state;
    w_cntNext       = r_cnt;
    w_isWordNext    = r_isWord;
    w_addrNext      = r_addr;
    w_dataNext      = r_data;
    w_memOpNext     = r_memOp;
    w_wrenNext      = r_wren;
    w_adrNext       = r_adr;
    w_doNext        = r_do;
    w_txValidNext   = r_txValid;
    w_txDataNext    = r_txData;
    w_cpuNResetNext = r_cpuNReset;

    case (r_state)
      ST_IDLE: begin
        if (rx_valid) begin
          case (rx_data)
            CMD_W, CMD_B: begin
              w_stateNext  = ST_ADDR;
              w_cntNext    = '0;
              w_isWordNext = (rx_data == CMD_W);
            end
            CMD_H, CMD_R: begin
              w_cpuNResetNext = (rx_data == CMD_R);
              w_stateNext     = ST_RESP;
              w_txValidNext   = 1'b1;
              w_txDataNext    = RSP_ACK;
            end
            default: begin
              w_stateNext   = ST_RESP;
              w_txValidNext = 1'b1;
              w_txDataNext  = RSP_NAK;
            end
          endcase
        end
      end

      ST_ADDR: begin
        if (rx_valid) begin
          w_addrNext = {rx_data, r_addr[31:8]};
          if (r_cnt == 2'd3) begin
            w_stateNext = ST_DATA;
            w_cntNext   = '0;
          end else begin
            w_cntNext = r_cnt + 2'd1;
          end
        end else if (w_expired) begin
          w_stateNext = ST_IDLE;
          w_cntNext   = '0;
        end
      end

      ST_DATA: begin
        if (rx_valid) begin
          if (r_isWord) begin
            w_dataNext = {rx_data, r_data[31:8]};
            if (r_cnt == 2'd3) begin
              w_stateNext = ST_WRITE;
              w_cntNext   = '0;
              w_memOpNext = 1'b1;
              w_wrenNext  = 4'hF;
              w_adrNext   = {r_addr[31:2], 2'b00};
              w_doNext    = {rx_data, r_data[31:8]};
            end else begin
              w_cntNext = r_cnt + 2'd1;
            end
          end else begin
            w_stateNext = ST_WRITE;
            w_cntNext   = '0;
            w_memOpNext = 1'b1;
            w_wrenNext  = 4'b0001 << r_addr[1:0];
            w_adrNext   = {r_addr[31:2], 2'b00};
            w_doNext    = {4{rx_data}};
          end
        end else if (w_expired) begin
          w_stateNext = ST_IDLE;
          w_cntNext   = '0;
        end
      end

      ST_WRITE: begin
        if (dbg_ack) begin
          w_stateNext   = ST_RESP;
          w_memOpNext   = 1'b0;
          w_wrenNext    = '0;
          w_txValidNext = 1'b1;
          w_txDataNext  = RSP_ACK;
        end
      end

      ST_RESP: begin
        if (tx_ready) begin
          w_stateNext   = ST_IDLE;
          w_txValidNext = 1'b0;
        end
      end

      default: begin
        w_stateNext = ST_IDLE;
      end
    endcase
  end

  assign tx_data     = r_txData;
  assign tx_valid    = r_txValid;
  assign cpu_n_reset = r_cpuNReset;
  assign dbg_mem_op  = r_memOp;
  assign dbg_wren    = r_wren;
  assign dbg_adr     = r_adr;
  assign dbg_do      = r_do;

endmodule

// File: tb/tb_dbg_uart_loader.sv
// Directed bench for dbg_uart_loader: frames, reset control, NAK, timeout, slow handshakes.
module tb_dbg_uart_loader;

  localparam int TMO = 40;

  logic        clk;
  logic        n_reset;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic        cpu_n_reset;
  logic        dbg_mem_op;
  logic [3:0]  dbg_wren;
  logic [31:0] dbg_adr;
  logic [31:0] dbg_do;
  logic        dbg_ack;

  int checkCount = 0;
  int errorCount = 0;
  int memOpCount = 0;
  int txCount    = 0;
  logic prevMemOp = 1'b0;

  dbg_uart_loader #(
    .TIMEOUT_CYCLES (TMO),
    .HOLD_ON_RESET  (1'b1)
  ) dut (
    .clk         (clk),
    .n_reset     (n_reset),
    .rx_data     (rx_data),
    .rx_valid    (rx_valid),
    .tx_data     (tx_data),
    .tx_valid    (tx_valid),
    .tx_ready    (tx_ready),
    .cpu_n_reset (cpu_n_reset),
    .dbg_mem_op  (dbg_mem_op),
    .dbg_wren    (dbg_wren),
    .dbg_adr     (dbg_adr),
    .dbg_do      (dbg_do),
    .dbg_ack     (dbg_ack)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Counts write requests and completed reply handshakes seen by the bus and UART.
  always @(posedge clk) begin
    if (dbg_mem_op && !prevMemOp) memOpCount++;
    prevMemOp = dbg_mem_op;
    if (tx_valid && tx_ready) txCount++;
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not complete in time");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [7:0] b);
    @(posedge clk); #1;
    rx_data  = b;
    rx_valid = 1'b1;
    @(posedge clk); #1;
    rx_valid = 1'b0;
  endtask

  task automatic applyFrame(input logic [7:0] f[$]);
    foreach (f[i]) applyStimulus(f[i]);
  endtask

  task automatic ackWrite();
    dbg_ack = 1'b1;
    @(posedge clk); #1;
    dbg_ack = 1'b0;
  endtask

  task automatic finishReply(input string tag, input logic [7:0] expByte);
    checkOutput({tag, "_txValid"}, 32'(tx_valid), 32'd1);
    checkOutput({tag, "_txData"}, 32'(tx_data), 32'(expByte));
    tx_ready = 1'b1;
    @(posedge clk); #1;
    tx_ready = 1'b0;
    checkOutput({tag, "_txDrop"}, 32'(tx_valid), 32'd0);
  endtask

  logic [7:0] frame[$];
  int memBefore;
  int txBefore;
  logic stableOk;

  initial begin
    n_reset  = 1'b0;
    rx_data  = '0;
    rx_valid = 1'b0;
    tx_ready = 1'b0;
    dbg_ack  = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_cpuNReset", 32'(cpu_n_reset), 32'd0);
    checkOutput("rst_memOp", 32'(dbg_mem_op), 32'd0);
    checkOutput("rst_wren", 32'(dbg_wren), 32'd0);
    checkOutput("rst_adr", dbg_adr, 32'd0);
    checkOutput("rst_do", dbg_do, 32'd0);
    checkOutput("rst_txValid", 32'(tx_valid), 32'd0);
    checkOutput("rst_txData", 32'(tx_data), 32'd0);
    n_reset = 1'b1;

    $display("[TB] word write 0x20000 <= 0x6F");
    frame = '{8'h57, 8'h00, 8'h00, 8'h02, 8'h00, 8'h6F, 8'h00, 8'h00, 8'h00};
    applyFrame(frame);
    checkOutput("w1_memOp", 32'(dbg_mem_op), 32'd1);
    checkOutput("w1_adr", dbg_adr, 32'h0002_0000);
    checkOutput("w1_do", dbg_do, 32'h0000_006F);
    checkOutput("w1_wren", 32'(dbg_wren), 32'hF);
    repeat (3) @(posedge clk);
    #1;
    checkOutput("w1_memOpHeld", 32'(dbg_mem_op), 32'd1);
    checkOutput("w1_txIdle", 32'(tx_valid), 32'd0);
    ackWrite();
    checkOutput("w1_memOpDrop", 32'(dbg_mem_op), 32'd0);
    checkOutput("w1_wrenDrop", 32'(dbg_wren), 32'd0);
    finishReply("w1", 8'h06);

    $display("[TB] byte write 0x20006 <= 0xA5");
    frame = '{8'h42, 8'h06, 8'h00, 8'h02, 8'h00, 8'hA5};
    applyFrame(frame);
    checkOutput("b1_memOp", 32'(dbg_mem_op), 32'd1);
    checkOutput("b1_adr", dbg_adr, 32'h0002_0004);
    checkOutput("b1_wren", 32'(dbg_wren), 32'h4);
    checkOutput("b1_do", dbg_do, 32'hA5A5_A5A5);
    ackWrite();
    finishReply("b1", 8'h06);

    frame = '{8'h42, 8'h07, 8'h00, 8'h00, 8'h00, 8'h3C};
    applyFrame(frame);
    checkOutput("b2_adr", dbg_adr, 32'h0000_0004);
    checkOutput("b2_wren", 32'(dbg_wren), 32'h8);
    checkOutput("b2_do", dbg_do, 32'h3C3C_3C3C);
    ackWrite();
    finishReply("b2", 8'h06);

    $display("[TB] core reset control");
    applyStimulus(8'h52);
    checkOutput("r_cpuNReset", 32'(cpu_n_reset), 32'd1);
    finishReply("r", 8'h06);
    applyStimulus(8'h48);
    checkOutput("h_cpuNReset", 32'(cpu_n_reset), 32'd0);
    finishReply("h", 8'h06);

    $display("[TB] unknown command");
    memBefore = memOpCount;
    applyStimulus(8'h33);
    checkOutput("nak_cpuNReset", 32'(cpu_n_reset), 32'd0);
    checkOutput("nak_memOp", 32'(dbg_mem_op), 32'd0);
    finishReply("nak", 8'h15);
    checkOutput("nak_noBus", 32'(memOpCount), 32'(memBefore));

    $display("[TB] inter-byte timeout");
    memBefore = memOpCount;
    txBefore  = txCount;
    frame = '{8'h57, 8'h00, 8'h00};
    applyFrame(frame);
    repeat (TMO + 10) @(posedge clk);
    #1;
    checkOutput("tmo_noBus", 32'(memOpCount), 32'(memBefore));
    checkOutput("tmo_noReply", 32'(txCount), 32'(txBefore));
    checkOutput("tmo_txValid", 32'(tx_valid), 32'd0);
    frame = '{8'h57, 8'h08, 8'h00, 8'h02, 8'h00, 8'h02, 8'h00, 8'h00, 8'h00};
    applyFrame(frame);
    checkOutput("tmo_memOp", 32'(dbg_mem_op), 32'd1);
    checkOutput("tmo_adr", dbg_adr, 32'h0002_0008);
    checkOutput("tmo_do", dbg_do, 32'h0000_0002);
    checkOutput("tmo_wren", 32'(dbg_wren), 32'hF);
    ackWrite();
    finishReply("tmo", 8'h06);

    $display("[TB] slow ack and slow transmitter");
    txBefore = txCount;
    frame = '{8'h57, 8'hF3, 8'h00, 8'h00, 8'h10, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
    applyFrame(frame);
    checkOutput("slow_adr", dbg_adr, 32'h1000_00F0);
    checkOutput("slow_do", dbg_do, 32'hDEAD_BEEF);
    applyStimulus(8'h52);
    stableOk = 1'b1;
    for (int i = 0; i < 48; i++) begin
      @(posedge clk); #1;
      if (dbg_mem_op !== 1'b1 || dbg_adr !== 32'h1000_00F0 || dbg_do !== 32'hDEAD_BEEF ||
          dbg_wren !== 4'hF || tx_valid !== 1'b0)
        stableOk = 1'b0;
    end
    checkOutput("slow_writeStable", 32'(stableOk), 32'd1);
    checkOutput("slow_droppedByte", 32'(cpu_n_reset), 32'd0);
    ackWrite();
    stableOk = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (tx_valid !== 1'b1 || tx_data !== 8'h06) stableOk = 1'b0;
    end
    checkOutput("slow_replyStable", 32'(stableOk), 32'd1);
    finishReply("slow", 8'h06);
    repeat (5) @(posedge clk);
    #1;
    checkOutput("slow_oneReply", 32'(txCount), 32'(txBefore + 1));

    $display("[TB] reset during write");
    applyStimulus(8'h52);
    finishReply("pre", 8'h06);
    frame = '{8'h57, 8'h10, 8'h00, 8'h00, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44};
    applyFrame(frame);
    checkOutput("rw_memOp", 32'(dbg_mem_op), 32'd1);
    #2;
    n_reset = 1'b0;
    #1;
    checkOutput("rw_memOpDrop", 32'(dbg_mem_op), 32'd0);
    checkOutput("rw_wren", 32'(dbg_wren), 32'd0);
    checkOutput("rw_adr", dbg_adr, 32'd0);
    checkOutput("rw_cpuNReset", 32'(cpu_n_reset), 32'd0);
    @(posedge clk); #1;
    n_reset = 1'b1;
    applyStimulus(8'h52);
    checkOutput("post_cpuNReset", 32'(cpu_n_reset), 32'd1);
    finishReply("post", 8'h06);

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule
